// File: rtl/magnitude_compare_sequencer_if.sv
// Handshake and operand/result bundle for magnitude_compare_sequencer.
// The master drives the request side and the slave returns status and results.
interface magnitude_compare_sequencer_if #(
    parameter int WIDTH_IN = 4,
    parameter int SLICES   = 4
) ();
    localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1;

    logic                         Start;
    logic [WIDTH_IN*SLICES-1:0]   A;
    logic [WIDTH_IN*SLICES-1:0]   B;
    logic                         ALess_in;
    logic                         Equal_in;
    logic                         AGreater_in;
    logic                         Busy;
    logic                         Done;
    logic [SW-1:0]                Slice;
    logic                         ALess_out;
    logic                         Equal_out;
    logic                         AGreater_out;

    modport master (
        output Start, A, B, ALess_in, Equal_in, AGreater_in,
        input  Busy, Done, Slice, ALess_out, Equal_out, AGreater_out
    );

    modport slave (
        input  Start, A, B, ALess_in, Equal_in, AGreater_in,
        output Busy, Done, Slice, ALess_out, Equal_out, AGreater_out
    );
endinterface

// File: rtl/magnitude_compare_sequencer.sv
// Wide magnitude compare: one 7485-style stage walked LSB slice to MSB slice, cascade fed back.
// Latency: Start accepted at edge t, Done high in the cycle after edge t+SLICES.
// Backpressure: none; Start is ignored while Busy, accepted in IDLE or in the Done cycle.
module magnitude_compare_sequencer #(
    parameter int WIDTH_IN   = 4,
    parameter int SLICES     = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    magnitude_compare_sequencer_if.slave bus
);
    localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int W  = WIDTH_IN * SLICES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [SW-1:0]   slice_q;
    logic            casc_l, casc_e, casc_g;
    logic            busy_q, done_q;
    logic            l_q, e_q, g_q;

    logic [WIDTH_IN-1:0] a_s;
    logic [WIDTH_IN-1:0] b_s;
    logic                nl, ne, ng;

    // Equal slices apply the raw 7485 cascade equations, so abnormal cascade codes propagate as the chip would.
    always_comb begin
        a_s = a_q[int'(slice_q)*WIDTH_IN +: WIDTH_IN];
        b_s = b_q[int'(slice_q)*WIDTH_IN +: WIDTH_IN];
        nl  = 1'b0;
        ne  = 1'b0;
        ng  = 1'b0;
        if (a_s > b_s) begin
            ng = 1'b1;
        end else if (a_s < b_s) begin
            nl = 1'b1;
        end else begin
            nl = !casc_g && !casc_e;
            ne = casc_e;
            ng = !casc_l && !casc_e;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            slice_q <= '0;
            casc_l  <= 1'b0;
            casc_e  <= 1'b0;
            casc_g  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        casc_l  <= bus.ALess_in;
                        casc_e  <= bus.Equal_in;
                        casc_g  <= bus.AGreater_in;
                        slice_q <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    casc_l <= nl;
                    casc_e <= ne;
                    casc_g <= ng;
                    if (slice_q != SW'(SLICES - 1)) begin
                        slice_q <= slice_q + SW'(1);
                    end else begin
                        l_q     <= nl;
                        e_q     <= ne;
                        g_q     <= ng;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        slice_q <= '0;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign #(DELAY_RISE, DELAY_FALL) bus.Busy         = busy_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.Done         = done_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.Slice        = slice_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.ALess_out    = l_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.Equal_out    = e_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.AGreater_out = g_q;
endmodule

// File: tb/tb_magnitude_compare_sequencer.sv
// Directed bench: results are checked by a Done-triggered scoreboard monitor; timing is checked inline.
module tb_magnitude_compare_sequencer;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;
    int   cyc;
    logic [2:0] exp_q[$];
    logic [2:0] held;

    magnitude_compare_sequencer_if #(.WIDTH_IN(4), .SLICES(4)) bus ();

    magnitude_compare_sequencer #(
        .WIDTH_IN(4), .SLICES(4), .DELAY_RISE(0), .DELAY_FALL(0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] outs();
        return {bus.ALess_out, bus.Equal_out, bus.AGreater_out};
    endfunction

    // Scoreboard monitor: every Done pops one expectation; outside Done the result must hold.
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            held = 3'b000;
        end else if (bus.Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(outs()), 32'h0);
                total--;
                bad++;
                $display("FAIL unexpected_done: got Done=1 expected no Done at %0t", $time);
            end else begin
                chk("result", 32'(outs()), 32'(exp_q.pop_front()));
            end
            held = outs();
        end else begin
            chk("hold", 32'(outs()), 32'(held));
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        bus.A = a;
        bus.B = b;
        {bus.ALess_in, bus.Equal_in, bus.AGreater_in} = c;
        bus.Start = 1'b1;
    endtask

    task automatic wait_done(output int c);
        int n;
        n = 0;
        @(negedge Clk);
        while (bus.Done !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("done_timeout", 32'(bus.Done), 32'h1);
        c = cyc;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                       input logic [2:0] expv);
        int dc;
        @(posedge Clk); #1;
        drive(a, b, c);
        exp_q.push_back(expv);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        wait_done(dc);
    endtask

    initial begin
        int d1, d2;
        total = 0;
        bad   = 0;
        held  = 3'b000;
        Reset = 1'b1;
        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.ALess_in = 1'b0;
        bus.Equal_in = 1'b0;
        bus.AGreater_in = 1'b0;

        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        chk("rst_done", 32'(bus.Done), 32'h0);
        chk("rst_slice", 32'(bus.Slice), 32'h0);
        chk("rst_outs", 32'(outs()), 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Equal words, normal cascade: check Busy/Slice/Done timing cycle by cycle.
        @(posedge Clk); #1;
        drive(16'h1234, 16'h1234, 3'b010);
        exp_q.push_back(3'b010);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("t1_busy", 32'(bus.Busy), 32'h1);
            chk("t1_done_low", 32'(bus.Done), 32'h0);
            chk("t1_slice", 32'(bus.Slice), 32'(i));
        end
        @(negedge Clk);
        chk("t1_busy_end", 32'(bus.Busy), 32'h0);
        chk("t1_done", 32'(bus.Done), 32'h1);
        chk("t1_slice_end", 32'(bus.Slice), 32'h0);
        @(negedge Clk);
        chk("t1_done_pulse", 32'(bus.Done), 32'h0);

        run(16'h0001, 16'h0000, 3'b010, 3'b001);
        run(16'h1000, 16'h0FFF, 3'b010, 3'b001);
        run(16'h0FFF, 16'h1000, 3'b010, 3'b100);
        run(16'h8000, 16'h7FFF, 3'b010, 3'b001);

        // Equal words across 4 slices: abnormal codes alternate each slice, an even count returns them.
        run(16'hA5A5, 16'hA5A5, 3'b100, 3'b100);
        run(16'hA5A5, 16'hA5A5, 3'b001, 3'b001);
        run(16'hA5A5, 16'hA5A5, 3'b000, 3'b000);
        run(16'hA5A5, 16'hA5A5, 3'b101, 3'b101);
        run(16'hA5A5, 16'hA5A5, 3'b111, 3'b010);

        // Start during RUN is ignored and operands stay latched.
        @(posedge Clk); #1;
        drive(16'h0001, 16'h0002, 3'b010);
        exp_q.push_back(3'b100);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        @(negedge Clk);
        chk("t4_slice0", 32'(bus.Slice), 32'h0);
        @(posedge Clk); #1;
        drive(16'hFFFF, 16'h0000, 3'b010);
        @(negedge Clk);
        chk("t4_slice1", 32'(bus.Slice), 32'h1);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        @(negedge Clk);
        chk("t4_slice2", 32'(bus.Slice), 32'h2);
        @(negedge Clk);
        chk("t4_slice3", 32'(bus.Slice), 32'h3);
        @(negedge Clk);
        chk("t4_done", 32'(bus.Done), 32'h1);
        repeat (8) @(negedge Clk);
        chk("t4_idle", 32'(bus.Busy), 32'h0);

        // Reset in Busy cycle 2 aborts with no Done and cleared outputs.
        @(posedge Clk); #1;
        drive(16'h00F0, 16'h0010, 3'b010);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("t5_busy", 32'(bus.Busy), 32'h0);
        chk("t5_done", 32'(bus.Done), 32'h0);
        chk("t5_outs", 32'(outs()), 32'h0);
        repeat (8) @(negedge Clk);
        chk("t5_still_idle", 32'(bus.Busy), 32'h0);
        run(16'h0005, 16'h0005, 3'b010, 3'b010);

        // Start held high: back-to-back runs with Done every 5 cycles.
        @(posedge Clk); #1;
        drive(16'hFFFF, 16'h0000, 3'b010);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b100);
        @(posedge Clk); #1;
        bus.A = 16'h0000;
        bus.B = 16'hFFFF;
        wait_done(d1);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        wait_done(d2);
        chk("t6_period", 32'(d2 - d1), 32'd5);
        repeat (4) @(negedge Clk);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end
endmodule
